// File: rtl/device_mux4.sv
// device_mux4: one TG68 master onto four peripheral slaves.
// Unmapped or stalled accesses are answered locally so the CPU never hangs.
module device_mux4 #(
    parameter int          TIMEOUT   = 255,
    parameter logic [15:0] OPEN_DATA = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] master_write,
    output logic [15:0] master_read,
    input  logic [31:0] master_addr,
    input  logic        master_uds,
    input  logic        master_lds,
    output logic        master_ack,
    input  logic [15:0] slave1_read,
    output logic [15:0] slave1_write,
    output logic [23:0] slave1_addr,
    output logic        slave1_uds,
    output logic        slave1_lds,
    input  logic        slave1_ack,
    input  logic [15:0] slave2_read,
    output logic [15:0] slave2_write,
    output logic [7:0]  slave2_addr,
    output logic        slave2_uds,
    output logic        slave2_lds,
    input  logic        slave2_ack,
    input  logic [15:0] slave3_read,
    output logic [15:0] slave3_write,
    output logic [7:0]  slave3_addr,
    output logic        slave3_uds,
    output logic        slave3_lds,
    input  logic        slave3_ack,
    input  logic [15:0] slave4_read,
    output logic [15:0] slave4_write,
    output logic [7:0]  slave4_addr,
    output logic        slave4_uds,
    output logic        slave4_lds,
    input  logic        slave4_ack
);

    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TO = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

    state_t        state_q, state_d;
    logic [3:0]    sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          open_q, open_d;

    logic          req;
    logic [3:0]    dec_sel;
    logic [3:0]    act_sel;
    logic          slv_ack;
    logic [15:0]   slv_read;
    logic          unused_addr_hi;

    assign req            = master_uds | master_lds;
    assign unused_addr_hi = ^master_addr[31:24];

    // Broadcast write data and addresses; only strobes are gated.
    assign slave1_write = master_write;
    assign slave2_write = master_write;
    assign slave3_write = master_write;
    assign slave4_write = master_write;
    assign slave1_addr  = master_addr[23:0];
    assign slave2_addr  = master_addr[7:0];
    assign slave3_addr  = master_addr[7:0];
    assign slave4_addr  = master_addr[7:0];

    // Address decode; bit0=slave1 .. bit3=slave4, zero means unmapped.
    always_comb begin
        dec_sel = 4'b0000;
        if (!master_addr[23])
            dec_sel = 4'b0001;
        else if (master_addr[23:8] == 16'hFFFD)
            dec_sel = 4'b1000;
        else if (master_addr[23:8] == 16'hFFFE)
            dec_sel = 4'b0100;
        else if (master_addr[23:8] == 16'hFFFF)
            dec_sel = 4'b0010;
    end

    // Ack and read data of the latched slave.
    always_comb begin
        slv_ack  = |(sel_q & {slave4_ack, slave3_ack, slave2_ack, slave1_ack});
        slv_read = ({16{sel_q[0]}} & slave1_read)
                 | ({16{sel_q[1]}} & slave2_read)
                 | ({16{sel_q[2]}} & slave3_read)
                 | ({16{sel_q[3]}} & slave4_read);
    end

    // Next-state logic: decode in IDLE, wait/timeout in ACTIVE, hold ack in HOLD.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        open_d  = open_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    sel_d = dec_sel;
                    cnt_d = '0;
                    if (dec_sel == 4'b0000) begin
                        open_d  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        open_d  = 1'b0;
                        state_d = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (!req) begin
                    state_d = IDLE;
                    sel_d   = 4'b0000;
                end else if (slv_ack) begin
                    state_d = HOLD;
                end else if (cnt_q == TO) begin
                    open_d  = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!req) begin
                    state_d = IDLE;
                    sel_d   = 4'b0000;
                    open_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 4'b0000;
                open_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= IDLE;
            sel_q   <= 4'b0000;
            cnt_q   <= '0;
            open_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            open_q  <= open_d;
        end
    end

    // Master-side outputs and gated slave strobes; all quiet during reset.
    always_comb begin
        act_sel     = 4'b0000;
        master_ack  = 1'b0;
        master_read = 16'h0000;
        if (!reset_n) begin
            unique case (state_q)
                IDLE: act_sel = dec_sel;
                ACTIVE: begin
                    act_sel     = sel_q;
                    master_ack  = slv_ack;
                    master_read = slv_read;
                end
                HOLD: begin
                    act_sel     = open_q ? 4'b0000 : sel_q;
                    master_ack  = 1'b1;
                    master_read = open_q ? OPEN_DATA : slv_read;
                end
                default: act_sel = 4'b0000;
            endcase
        end
        slave1_uds = act_sel[0] & master_uds;
        slave1_lds = act_sel[0] & master_lds;
        slave2_uds = act_sel[1] & master_uds;
        slave2_lds = act_sel[1] & master_lds;
        slave3_uds = act_sel[2] & master_uds;
        slave3_lds = act_sel[2] & master_lds;
        slave4_uds = act_sel[3] & master_uds;
        slave4_lds = act_sel[3] & master_lds;
    end

endmodule

// File: tb/tb_device_mux4.sv
// tb_device_mux4: directed checks of decode, strobe gating,
// ack/data return, open-bus answers, timeout and reset.
module tb_device_mux4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] master_write, master_read;
    logic [31:0] master_addr;
    logic        master_uds, master_lds, master_ack;
    logic [15:0] slave1_read, slave1_write;
    logic [23:0] slave1_addr;
    logic        slave1_uds, slave1_lds, slave1_ack;
    logic [15:0] slave2_read, slave2_write;
    logic [7:0]  slave2_addr;
    logic        slave2_uds, slave2_lds, slave2_ack;
    logic [15:0] slave3_read, slave3_write;
    logic [7:0]  slave3_addr;
    logic        slave3_uds, slave3_lds, slave3_ack;
    logic [15:0] slave4_read, slave4_write;
    logic [7:0]  slave4_addr;
    logic        slave4_uds, slave4_lds, slave4_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    device_mux4 #(.TIMEOUT(8), .OPEN_DATA(16'hFFFF)) dut (
        .clk(clk), .reset_n(reset_n),
        .master_write(master_write), .master_read(master_read),
        .master_addr(master_addr), .master_uds(master_uds),
        .master_lds(master_lds), .master_ack(master_ack),
        .slave1_read(slave1_read), .slave1_write(slave1_write),
        .slave1_addr(slave1_addr), .slave1_uds(slave1_uds),
        .slave1_lds(slave1_lds), .slave1_ack(slave1_ack),
        .slave2_read(slave2_read), .slave2_write(slave2_write),
        .slave2_addr(slave2_addr), .slave2_uds(slave2_uds),
        .slave2_lds(slave2_lds), .slave2_ack(slave2_ack),
        .slave3_read(slave3_read), .slave3_write(slave3_write),
        .slave3_addr(slave3_addr), .slave3_uds(slave3_uds),
        .slave3_lds(slave3_lds), .slave3_ack(slave3_ack),
        .slave4_read(slave4_read), .slave4_write(slave4_write),
        .slave4_addr(slave4_addr), .slave4_uds(slave4_uds),
        .slave4_lds(slave4_lds), .slave4_ack(slave4_ack)
    );

    function automatic logic [7:0] strobes();
        return {slave4_uds, slave4_lds, slave3_uds, slave3_lds,
                slave2_uds, slave2_lds, slave1_uds, slave1_lds};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        step();
        master_addr = 32'h0000_0100;
        master_uds = 1'b1;
        #1;
        n_tests++;
        if (master_ack !== 1'b0 || master_read !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_out ack=%b read=%h want 0/0000",
                     master_ack, master_read);
        end
        n_tests++;
        if (strobes() !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_strobes got %b want 00000000", strobes());
        end
        master_uds = 1'b0;
        reset_n = 1'b0;
        step();
    endtask

    task automatic test_slave1_read();
        master_addr = 32'hAB00_0100;
        master_uds = 1'b1;
        master_lds = 1'b1;
        #1;
        n_tests++;
        if (strobes() !== 8'b0000_0011) begin
            n_fail++;
            $display("FAIL s1_idle_strobes got %b want 00000011", strobes());
        end
        step();
        step();
        n_tests++;
        if (master_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL s1_early_ack got %b want 0", master_ack);
        end
        step();
        slave1_ack = 1'b1;
        slave1_read = 16'h1234;
        #1;
        n_tests++;
        if (master_ack !== 1'b1 || master_read !== 16'h1234) begin
            n_fail++;
            $display("FAIL s1_ack ack=%b read=%h want 1/1234",
                     master_ack, master_read);
        end
        step();
        slave1_ack = 1'b0;
        #1;
        n_tests++;
        if (master_ack !== 1'b1 || strobes() !== 8'b0000_0011) begin
            n_fail++;
            $display("FAIL s1_hold ack=%b strobes=%b want 1/00000011",
                     master_ack, strobes());
        end
        master_uds = 1'b0;
        master_lds = 1'b0;
        step();
        n_tests++;
        if (master_ack !== 1'b0 || master_read !== 16'h0000) begin
            n_fail++;
            $display("FAIL s1_release ack=%b read=%h want 0/0000",
                     master_ack, master_read);
        end
    endtask

    task automatic test_slave2_write();
        master_addr = 32'h00FF_FF01;
        master_write = 16'h0041;
        master_lds = 1'b1;
        #1;
        n_tests++;
        if (strobes() !== 8'b0000_0100 || slave2_addr !== 8'h01
            || slave2_write !== 16'h0041) begin
            n_fail++;
            $display("FAIL s2_write strobes=%b addr=%h data=%h want 00000100/01/0041",
                     strobes(), slave2_addr, slave2_write);
        end
        step();
        n_tests++;
        if (master_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL s2_early_ack got %b want 0", master_ack);
        end
        slave2_ack = 1'b1;
        #1;
        n_tests++;
        if (master_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL s2_ack got %b want 1", master_ack);
        end
        step();
        slave2_ack = 1'b0;
        master_lds = 1'b0;
        step();
    endtask

    task automatic test_slave3_slave4();
        slave1_read = 16'h1111;
        master_addr = 32'h00FF_FE00;
        master_uds = 1'b1;
        master_lds = 1'b1;
        #1;
        n_tests++;
        if (strobes() !== 8'b0011_0000 || slave3_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL s3_sel strobes=%b addr=%h want 00110000/00",
                     strobes(), slave3_addr);
        end
        step();
        slave4_ack = 1'b1;
        #1;
        n_tests++;
        if (master_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL s3_foreign_ack got %b want 0", master_ack);
        end
        slave4_ack = 1'b0;
        slave3_ack = 1'b1;
        #1;
        n_tests++;
        if (master_ack !== 1'b1 || master_read !== 16'h3333) begin
            n_fail++;
            $display("FAIL s3_read ack=%b read=%h want 1/3333",
                     master_ack, master_read);
        end
        step();
        slave3_ack = 1'b0;
        master_uds = 1'b0;
        master_lds = 1'b0;
        step();
        master_addr = 32'h00FF_FD04;
        master_uds = 1'b1;
        #1;
        n_tests++;
        if (strobes() !== 8'b1000_0000 || slave4_addr !== 8'h04) begin
            n_fail++;
            $display("FAIL s4_sel strobes=%b addr=%h want 10000000/04",
                     strobes(), slave4_addr);
        end
        step();
        slave4_ack = 1'b1;
        #1;
        n_tests++;
        if (master_ack !== 1'b1 || master_read !== 16'h4444) begin
            n_fail++;
            $display("FAIL s4_read ack=%b read=%h want 1/4444",
                     master_ack, master_read);
        end
        step();
        slave4_ack = 1'b0;
        master_uds = 1'b0;
        step();
    endtask

    task automatic test_unmapped();
        master_addr = 32'h0090_0000;
        master_uds = 1'b1;
        master_lds = 1'b1;
        #1;
        n_tests++;
        if (master_ack !== 1'b0 || strobes() !== 8'h00) begin
            n_fail++;
            $display("FAIL unm_idle ack=%b strobes=%b want 0/00000000",
                     master_ack, strobes());
        end
        step();
        n_tests++;
        if (master_ack !== 1'b1 || master_read !== 16'hFFFF
            || strobes() !== 8'h00) begin
            n_fail++;
            $display("FAIL unm_ack ack=%b read=%h strobes=%b want 1/FFFF/00000000",
                     master_ack, master_read, strobes());
        end
        step();
        n_tests++;
        if (master_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL unm_hold got %b want 1", master_ack);
        end
        master_uds = 1'b0;
        master_lds = 1'b0;
        step();
        n_tests++;
        if (master_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL unm_release got %b want 0", master_ack);
        end
    endtask

    task automatic test_timeout();
        master_addr = 32'h0000_0200;
        master_uds = 1'b1;
        master_lds = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            n_tests++;
            if (master_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL to_wait cycle %0d ack=%b want 0", i, master_ack);
            end
        end
        step();
        n_tests++;
        if (master_ack !== 1'b1 || master_read !== 16'hFFFF
            || strobes() !== 8'h00) begin
            n_fail++;
            $display("FAIL to_ack ack=%b read=%h strobes=%b want 1/FFFF/00000000",
                     master_ack, master_read, strobes());
        end
        master_uds = 1'b0;
        master_lds = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        master_addr = 32'h0000_0300;
        master_uds = 1'b1;
        step();
        step();
        reset_n = 1'b1;
        #1;
        n_tests++;
        if (master_ack !== 1'b0 || strobes() !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid ack=%b strobes=%b want 0/00000000",
                     master_ack, strobes());
        end
        step();
        reset_n = 1'b0;
        slave1_ack = 1'b1;
        #1;
        n_tests++;
        if (master_ack !== 1'b0 || master_read !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_idle ack=%b read=%h want 0/0000",
                     master_ack, master_read);
        end
        slave1_ack = 1'b0;
        master_uds = 1'b0;
        step();
    endtask

    task automatic test_addr_change();
        master_addr = 32'h00FF_FF10;
        master_uds = 1'b1;
        step();
        master_addr = 32'h0000_0010;
        #1;
        n_tests++;
        if (strobes() !== 8'b0000_1000) begin
            n_fail++;
            $display("FAIL addr_chg strobes=%b want 00001000", strobes());
        end
        slave2_read = 16'h5A5A;
        slave2_ack = 1'b1;
        #1;
        n_tests++;
        if (master_ack !== 1'b1 || master_read !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL addr_chg_read ack=%b read=%h want 1/5A5A",
                     master_ack, master_read);
        end
        step();
        slave2_ack = 1'b0;
        master_uds = 1'b0;
        step();
    endtask

    initial begin
        reset_n = 1'b1;
        master_write = 16'h0000;
        master_addr = 32'h0;
        master_uds = 1'b0;
        master_lds = 1'b0;
        slave1_read = 16'h1111;
        slave2_read = 16'h2222;
        slave3_read = 16'h3333;
        slave4_read = 16'h4444;
        slave1_ack = 1'b0;
        slave2_ack = 1'b0;
        slave3_ack = 1'b0;
        slave4_ack = 1'b0;
        test_reset();
        test_slave1_read();
        test_slave2_write();
        test_slave3_slave4();
        test_unmapped();
        test_timeout();
        test_reset_mid();
        test_addr_change();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
